i2s_rx: RTL

//  Front end of the audio path: deserialises an external I2S stream into the parallel stereo sample bus +

---
 rtl/i2s_rx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples async I2S pins on clk, assembles left/right slots, and emits a stereo pair.
// Optional link-loss watchdog is enabled by defining I2S_RX_WATCHDOG_EN.
module i2s_rx #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned WDOG_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i2s_bclk,
   input  logic                   i2s_lrclk,
   input  logic                   i2s_sdata,
   output logic [1:0][DATA_W-1:0] audio_out,
   output logic                   sample_en,
   output logic                   link_ok,
   output logic                   frame_err
);
   typedef enum logic [1:0] {StSync, StLeft, StRight} state_e;

   localparam logic [5:0] DataWC = 6'(DATA_W);

   if (DATA_W < 2 || DATA_W > 62 || WDOG_CYC < 2) begin : g_bad_param
      $error("i2s_rx: unsupported parameter values");
   end

   logic [1:0]             bclk_sync_q, lr_sync_q, sd_sync_q;
   logic                   bclk_prev_q;
   logic                   rise_q, lr_smp_q, sd_smp_q;
   state_e                 state_q, state_d;
   logic                   lr_q, lr_d;
   logic [5:0]             cnt_q, cnt_d;
   logic [DATA_W-1:0]      shreg_q, shreg_d, hold_q, hold_d;
   logic [1:0][DATA_W-1:0] audio_q, audio_d;
   logic                   sample_en_q, sample_en_d;
   logic                   link_ok_q, link_ok_d;
   logic                   frame_err_q, frame_err_d;
   logic                   timeout;

   logic [5:0]             cnt_inc;
   logic [DATA_W-1:0]      shreg_in, slot_val;
   logic                   slot_end, slot_short;

   // Strobe and sampled lrclk/sdata are registered together so they stay aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         bclk_sync_q <= '0;
         lr_sync_q   <= '0;
         sd_sync_q   <= '0;
         bclk_prev_q <= 1'b0;
         rise_q      <= 1'b0;
         lr_smp_q    <= 1'b0;
         sd_smp_q    <= 1'b0;
      end else begin
         bclk_sync_q <= {bclk_sync_q[0], i2s_bclk};
         lr_sync_q   <= {lr_sync_q[0], i2s_lrclk};
         sd_sync_q   <= {sd_sync_q[0], i2s_sdata};
         bclk_prev_q <= bclk_sync_q[1];
         rise_q      <= bclk_sync_q[1] & ~bclk_prev_q;
         lr_smp_q    <= lr_sync_q[1];
         sd_smp_q    <= sd_sync_q[1];
      end
   end

`ifdef I2S_RX_WATCHDOG_EN
   localparam int unsigned WdogW = $clog2(WDOG_CYC + 1);
   localparam logic [WdogW-1:0] WdogMax = WdogW'(WDOG_CYC);

   logic [WdogW-1:0] wdog_q;

   always_ff @(posedge clk) begin
      if (reset || rise_q) begin
         wdog_q <= '0;
      end else if (wdog_q != WdogMax) begin
         wdog_q <= wdog_q + WdogW'(1);
      end
   end

   assign timeout = (wdog_q == WdogMax);
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      cnt_inc     = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
      shreg_in    = (cnt_q < DataWC) ? {shreg_q[DATA_W-2:0], sd_smp_q} : shreg_q;
      slot_short  = (cnt_inc < DataWC);
      slot_val    = slot_short ? (shreg_in << (DataWC - cnt_inc)) : shreg_in;
      slot_end    = (lr_smp_q != lr_q);

      state_d     = state_q;
      lr_d        = lr_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      hold_d      = hold_q;
      audio_d     = audio_q;
      link_ok_d   = link_ok_q;
      sample_en_d = 1'b0;
      frame_err_d = 1'b0;

      if (rise_q) begin
         lr_d = lr_smp_q;
         case (state_q)
            StSync: begin
               // Lock on the R->L edge; that rise still carries the previous right LSB.
               if (lr_q && !lr_smp_q) begin
                  state_d = StLeft;
                  cnt_d   = '0;
                  shreg_d = '0;
               end
            end
            StLeft, StRight: begin
               if (slot_end) begin
                  cnt_d       = '0;
                  shreg_d     = '0;
                  frame_err_d = slot_short;
                  if (state_q == StLeft) begin
                     hold_d  = slot_val;
                     state_d = StRight;
                  end else begin
                     audio_d     = {slot_val, hold_q};
                     sample_en_d = 1'b1;
                     link_ok_d   = 1'b1;
                     state_d     = StLeft;
                  end
               end else begin
                  cnt_d   = cnt_inc;
                  shreg_d = shreg_in;
               end
            end
            default: state_d = StSync;
         endcase
      end

      if (timeout) begin
         state_d     = StSync;
         cnt_d       = '0;
         shreg_d     = '0;
         audio_d     = '0;
         link_ok_d   = 1'b0;
         sample_en_d = 1'b0;
         frame_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StSync;
         lr_q        <= 1'b0;
         cnt_q       <= '0;
         shreg_q     <= '0;
         hold_q      <= '0;
         audio_q     <= '0;
         sample_en_q <= 1'b0;
         link_ok_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lr_q        <= lr_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         hold_q      <= hold_d;
         audio_q     <= audio_d;
         sample_en_q <= sample_en_d;
         link_ok_q   <= link_ok_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign audio_out = audio_q;
   assign sample_en = sample_en_q;
   assign link_ok   = link_ok_q;
   assign frame_err = frame_err_q;

endmodule
